// File: rtl/gf_mult_pkg.sv
// Shared types and constants for the bit-serial GF(2)[x] / integer multiplier.
package gf_mult_pkg;

    typedef enum logic [1:0] {
        GF_IDLE   = 2'd0,
        GF_MUL    = 2'd1,
        GF_REDUCE = 2'd2,
        GF_DONE   = 2'd3
    } gf_mult_state_t;

    localparam logic [31:0] GF_POLY_DEFAULT = 32'h0000_008D;

    // Ceiling log2, usable in constant expressions for counter sizing.
    function automatic int gf_clog2(input int value);
        int result;
        result = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) begin
                result = k + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/gf_serial_mult_if.sv
// Operand/result handshake bundle for gf_serial_mult; slave is the multiplier side.
interface gf_serial_mult_if #(
    parameter int WIDTH = 32
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 carry_option;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, carry_option, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, carry_option, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/gf_pp_acc.sv
// Partial-product combiner: integer add when carry_option=1, carry-less XOR otherwise.
module gf_pp_acc #(
    parameter int W2 = 64
) (
    input  logic [W2-1:0] acc,
    input  logic [W2-1:0] pp,
    input  logic          carry_option,
    output logic [W2-1:0] acc_next
);

    assign acc_next = carry_option ? (acc + pp) : (acc ^ pp);

endmodule

// File: rtl/gf_serial_mult.sv
// Bit-serial integer / carry-less multiplier behind a valid/ready handshake.
// Define GF_SERIAL_MULT_REDUCE_EN to reduce carry-less results modulo x^WIDTH + POLY.
module gf_serial_mult
    import gf_mult_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF_POLY_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    gf_serial_mult_if.slave bus
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = gf_clog2(W2);

    localparam logic [1:0] S_IDLE   = 2'(GF_IDLE);
    localparam logic [1:0] S_MUL    = 2'(GF_MUL);
    localparam logic [1:0] S_DONE   = 2'(GF_DONE);
`ifdef GF_SERIAL_MULT_REDUCE_EN
    localparam logic [1:0] S_REDUCE = 2'(GF_REDUCE);
    localparam logic [W2-1:0] POLY_FULL = {{(WIDTH-1){1'b0}}, 1'b1, POLY};
`endif

    logic [1:0]       state_reg;
    logic [W2-1:0]    acc_reg;
    logic [W2-1:0]    a_shift_reg;
    logic [WIDTH-1:0] b_shift_reg;
    logic             mode_reg;
    logic [CW-1:0]    cnt_reg;
    logic [W2-1:0]    product_reg;
`ifdef GF_SERIAL_MULT_REDUCE_EN
    logic [W2-1:0]    poly_shift_reg;
`endif

    logic [W2-1:0]    pp_next;
    logic             pp_mode_next;
    logic [W2-1:0]    acc_next;

    // Operands are pre-shifted in registers so each step only needs the LSB of b.
    always_comb begin
        pp_next      = '0;
        pp_mode_next = mode_reg;
        if (state_reg == S_MUL && b_shift_reg[0]) begin
            pp_next = a_shift_reg;
        end
`ifdef GF_SERIAL_MULT_REDUCE_EN
        if (state_reg == S_REDUCE) begin
            pp_mode_next = 1'b0;
            if (acc_reg[cnt_reg]) begin
                pp_next = poly_shift_reg;
            end
        end
`endif
    end

    gf_pp_acc #(.W2(W2)) u_pp_acc (
        .acc          (acc_reg),
        .pp           (pp_next),
        .carry_option (pp_mode_next),
        .acc_next     (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            acc_reg        <= '0;
            a_shift_reg    <= '0;
            b_shift_reg    <= '0;
            mode_reg       <= 1'b0;
            cnt_reg        <= '0;
            product_reg    <= '0;
`ifdef GF_SERIAL_MULT_REDUCE_EN
            poly_shift_reg <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_shift_reg <= {{WIDTH{1'b0}}, bus.a};
                        b_shift_reg <= bus.b;
                        mode_reg    <= bus.carry_option;
                        acc_reg     <= '0;
                        cnt_reg     <= '0;
                        state_reg   <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_reg     <= acc_next;
                    a_shift_reg <= a_shift_reg << 1;
                    b_shift_reg <= b_shift_reg >> 1;
                    cnt_reg     <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
`ifdef GF_SERIAL_MULT_REDUCE_EN
                        if (!mode_reg) begin
                            // Reduction scans acc bits 2W-2 down to W, polynomial aligned to the top one.
                            state_reg      <= S_REDUCE;
                            cnt_reg        <= CW'(W2 - 2);
                            poly_shift_reg <= POLY_FULL << (WIDTH - 2);
                        end else
`endif
                        begin
                            state_reg   <= S_DONE;
                            product_reg <= acc_next;
                        end
                    end
                end
`ifdef GF_SERIAL_MULT_REDUCE_EN
                S_REDUCE: begin
                    acc_reg        <= acc_next;
                    poly_shift_reg <= poly_shift_reg >> 1;
                    cnt_reg        <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(WIDTH)) begin
                        state_reg   <= S_DONE;
                        product_reg <= acc_next;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == S_IDLE);
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.product   = product_reg;

endmodule

// File: doc/gf_serial_mult.md
# gf_serial_mult

Bit-serial, parametrised multiplier that builds on the team's adder-mode comparison work. A per-operation `carry_option` selects integer multiplication (carry-propagating add of partial products) or carry-less GF(2)[x] multiplication (XOR of partial products). Optionally, it reduces carry-less results modulo an irreducible polynomial. It sits behind a valid/ready handshake so GF datapaths can stream operands through it.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 2.
- `POLY`, 32'h0000_008D: lower WIDTH bits of the reduction polynomial. The x^WIDTH term is implicit. Used only with GF_REDUCE_EN.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair is valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: multiplicand.
- `b` in WIDTH: multiplier, scanned LSB first.
- `carry_option` in 1: 1 = integer multiply; 0 = carry-less multiply.
- `out_valid` out 1: `product` is valid.
- `out_ready` in 1: consumer accepts the result.
- `product` out 2*WIDTH: result. In reduced mode, the upper WIDTH bits are zero.

## Operation
- FSM states: IDLE, MUL, REDUCE (present only with GF_REDUCE_EN), DONE.
- **IDLE:** `in_ready`=1.
  - On `in_valid && in_ready`, latch `a`, `b` and `carry_option`.
  - Clear the accumulator, clear bit counter `i`, then go to MUL.
- **MUL:** runs WIDTH cycles, i = 0..WIDTH-1.
  - If `b[i]`=1, combine `a << i` into the 2*WIDTH-bit accumulator: add if `carry_option`=1, XOR if 0.
  - Integer add never overflows 2*WIDTH bits; no carry is lost.
  - After i = WIDTH-1: go to REDUCE if reduction applies, else go to DONE.
- **REDUCE:** applies only when `carry_option`=0 and the macro is defined. Runs WIDTH-1 cycles, j = 2*WIDTH-2 down to WIDTH.
  - If `acc[j]`=1, XOR `{1'b1, POLY} << (j-WIDTH)` into the accumulator.
  - Then go to DONE.
- **DONE:** `out_valid`=1 and `product` = accumulator, held stable until `out_ready`=1.
  - When `out_ready`=1, return to IDLE at the next edge.
- `in_ready`=0 in every state except IDLE. No operand overlap; a new accept cannot occur in the same cycle as result handoff.
- Operand or mode changes on the inputs after acceptance have no effect.
- `in_valid` while busy is ignored. The source must hold the request until it sees `in_ready`.
- `a`=0 or `b`=0 yields `product`=0 after the full latency; there is no early exit.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `product`=0. FSM in IDLE, accumulator and counters zero.
- Asserting `rst` mid-operation aborts the operation immediately. The operation is discarded and no `out_valid` is produced.
- Latency, measured from the accept edge to the first edge at which `out_valid` is sampled high:
  - WIDTH cycles for integer mode, or carry-less mode without reduction.
  - 2*WIDTH-1 cycles for carry-less mode with reduction.
- If `out_ready`=1 while in DONE, the result is held for exactly one cycle. `in_ready` rises on the following cycle.
- Minimum issue interval: latency + 2 cycles.
- `product` is registered. It changes only on the edge entering DONE, and on reset.

## Configuration
- Macro: `GF_SERIAL_MULT_REDUCE_EN`.
- **Defined:** the REDUCE state and `POLY` logic are built. Carry-less results are reduced modulo x^WIDTH + POLY, with the upper half zero.
- **Undefined:** REDUCE is not built and `POLY` is ignored. Carry-less results are the full 2*WIDTH-1-bit unreduced product.
- Integer mode behaves identically in both builds.

## Structure
- Package `gf_mult_pkg` contains:
  - the FSM state enum `gf_mult_state_t`;
  - the default `POLY` constant `GF_POLY_DEFAULT`;
  - the counter-width function `gf_clog2`.
- Sub-module `gf_pp_acc` is combinational. Its inputs are accumulator, shifted partial product and `carry_option`; its output is the next accumulator (add or XOR). It is shared by MUL and, via the XOR path, by REDUCE.

## Test plan
- **Integer vs carry-less, WIDTH=32:**
  - a=7, b=7, `carry_option`=1 → `product`=49 after 32 cycles.
  - Same operands, `carry_option`=0 → `product`=21.
- **No-overlap case, WIDTH=32:** a=10, b=25 → `product`=250 in both modes. Confirms mode affects only overlapping bits.
- **Reduction, WIDTH=8, POLY=8'h1B, macro defined:** a=8'h57, b=8'h83, `carry_option`=0 → `product`=16'h00C1 after 15 cycles. Without the macro → 16'h2B79 after 8 cycles.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → `product` and `out_valid` stay stable, `in_ready` stays 0. Release → one handoff, then `in_ready`=1.
- **Reset mid-MUL:** assert `rst` at i=10 (WIDTH=32) → `out_valid`=0, `product`=0, `in_ready`=1. The next operation (a=3, b=3, `carry_option`=1) gives 9.
- **Max integer, WIDTH=8:** a=b=8'hFF, `carry_option`=1 → `product`=16'hFE01, with no truncation.
